hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have no parameters; register index width is fixed at 5 bits and counter widths are fixed as given below.
REQ-002 h_i_clk  in  1  single clock; all state changes occur on its rising edge.
REQ-003 h_i_rst  in  1  reset, asynchronous, active-high.
REQ-004 h_i_ce  in  1  enable; when low, the pipeline is frozen and all state and counters hold.
REQ-005 h_i_id_valid, h_i_id_uses_rt  in  1 each  ID holds a decoded instruction / that instruction reads rt.
REQ-006 h_i_id_rs, h_i_id_rt  in  5 each  source register addresses in ID.
REQ-007 h_i_ex_memread, h_i_ex_reg_wr  in  1 each  the ID/EX instruction is a load / writes a register.
REQ-008 h_i_ex_rd  in  5  destination register of the ID/EX instruction (after reg_dst selection).
REQ-009 h_i_ex_branch_taken  in  1  a branch in EX resolved as taken this cycle.
REQ-010 h_i_mem_req, h_i_mem_ack  in  1 each  MEM stage has a load/store outstanding / data memory completes it this cycle.
REQ-011 h_o_pc_we, h_o_ifid_we, h_o_idex_we, h_o_exmem_we  out  1 each  write enables for PC, IF/ID, ID/EX and EX/MEM.
REQ-012 h_o_ifid_flush, h_o_idex_bubble  out  1 each  clear IF/ID / load zero controls into ID/EX at the next edge.
REQ-013 h_o_state  out  2  current FSM state: RUN=0, LOAD_STALL=1, MEM_WAIT=2; the value 3 is unused.
REQ-014 h_o_stall_cnt  out  16  saturating count of cycles in which h_o_pc_we=0 while h_i_ce=1.
REQ-015 h_o_mem_timeout  out  1  sticky flag set when a memory wait exceeds 255 cycles.

Function
REQ-016 The outputs in REQ-011/012 SHALL be combinational functions of the registered state and the current inputs, evaluated in priority order REQ-017 > REQ-018 > REQ-019 > REQ-020 > REQ-021.
REQ-017 When h_i_rst=1 or h_i_ce=0, all enables, h_o_ifid_flush and h_o_idex_bubble SHALL be 0.
REQ-018 Freeze, F = h_i_mem_req & ~h_i_mem_ack: all four enables SHALL be 0 and flush/bubble SHALL be 0.
REQ-019 When h_i_ex_branch_taken=1 and F=0: pc_we=ifid_we=idex_we=exmem_we=1 and ifid_flush=idex_bubble=1; any coincident load-use hazard is ignored.
REQ-020 Load-use hazard, LU = id_valid & ex_memread & ex_reg_wr & (ex_rd!=0) & ((ex_rd==id_rs) | (id_uses_rt & ex_rd==id_rt)): pc_we=0, ifid_we=0, idex_we=1, exmem_we=1, idex_bubble=1, ifid_flush=0.
REQ-021 Otherwise all four enables SHALL be 1 and flush/bubble SHALL be 0.
REQ-022 FSM transitions, taken only when h_i_ce=1:
  - RUN: goes to MEM_WAIT if F; else to LOAD_STALL if LU & ~branch_taken; else stays in RUN.
  - LOAD_STALL: goes to MEM_WAIT if F; else to RUN (stall lasts exactly one cycle per hazard).
  - MEM_WAIT: stays while F; goes to RUN on the cycle h_i_mem_ack=1 or h_i_mem_req=0.
REQ-023 Back-to-back hazards: if LU holds again in LOAD_STALL, the outputs SHALL stall again per REQ-020 and the next state SHALL be RUN.
REQ-024 Wait counter (8-bit, internal): cleared on every cycle outside MEM_WAIT; increments each cycle in MEM_WAIT; on reaching 255 while still F, it SHALL set h_o_mem_timeout and hold at 255.
REQ-025 h_o_mem_timeout SHALL clear only on reset; the block keeps stalling while F holds, regardless of the timeout.
REQ-026 h_o_stall_cnt SHALL increment by 1 per qualifying cycle and saturate at 16'hFFFF.
REQ-027 An ack in the same cycle as a request SHALL give F=0, so no stall occurs.

Reset
REQ-028 On assertion of h_i_rst, asynchronously: state=RUN, h_o_stall_cnt=0, wait counter=0, h_o_mem_timeout=0; the combinational outputs follow REQ-017.
REQ-029 Reset asserted mid-stall or mid-wait SHALL abandon the stall or wait immediately; after release the FSM starts in RUN with no residual stall.

Verification
REQ-030 Load-use: ex_memread=1, ex_reg_wr=1, ex_rd=5, id_rs=5, id_valid=1 -> pc_we=0, ifid_we=0, idex_bubble=1 for exactly one cycle; state RUN->LOAD_STALL->RUN; stall_cnt=1.
REQ-031 $zero and rt filtering: ex_rd=0 matching rs -> no stall; ex_rd=7=id_rt with id_uses_rt=0 -> no stall; same case with id_uses_rt=1 -> stall.
REQ-032 Branch plus hazard: branch_taken=1 together with LU -> ifid_flush=1, idex_bubble=1, pc_we=1; state stays RUN.
REQ-033 Memory wait: mem_req=1, ack low for 3 cycles then high -> all enables 0 for 3 cycles; state MEM_WAIT for 3 cycles then RUN; stall_cnt=3; a concurrent branch is not flushed until F=0.
REQ-034 Timeout: mem_req=1, ack=0 for 300 cycles -> h_o_mem_timeout rises after the 255th wait cycle and stays 1 after ack, until reset.
REQ-035 Reset mid-MEM_WAIT: assert h_i_rst asynchronously -> state=0, stall_cnt=0, timeout=0 immediately, with no clock edge required.

Source files
------------

// File: rtl/hazard_unit.sv
// Pipeline hazard control: load-use stalls, taken-branch flushes and memory-wait freezes,
// plus a saturating stall-cycle counter and a sticky memory-timeout flag.
module hazard_unit (
  input  logic        h_i_clk,
  input  logic        h_i_rst,
  input  logic        h_i_ce,
  input  logic        h_i_id_valid,
  input  logic        h_i_id_uses_rt,
  input  logic [4:0]  h_i_id_rs,
  input  logic [4:0]  h_i_id_rt,
  input  logic        h_i_ex_memread,
  input  logic        h_i_ex_reg_wr,
  input  logic [4:0]  h_i_ex_rd,
  input  logic        h_i_ex_branch_taken,
  input  logic        h_i_mem_req,
  input  logic        h_i_mem_ack,
  output logic        h_o_pc_we,
  output logic        h_o_ifid_we,
  output logic        h_o_idex_we,
  output logic        h_o_exmem_we,
  output logic        h_o_ifid_flush,
  output logic        h_o_idex_bubble,
  output logic [1:0]  h_o_state,
  output logic [15:0] h_o_stall_cnt,
  output logic        h_o_mem_timeout
);

  localparam logic [1:0] ST_RUN        = 2'd0;
  localparam logic [1:0] ST_LOAD_STALL = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT   = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [7:0]  waitCnt_q, waitCnt_d, waitInc;
  logic [15:0] stallCnt_q, stallCnt_d;
  logic        timeout_q, timeout_d;

  logic freeze, loadUse, rsMatch, rtMatch, inWait;
  logic pcWe, ifidWe, idexWe, exmemWe, flush, bubble;

  // An ack in the same cycle as the request completes the access, so it does not freeze.
  assign freeze  = h_i_mem_req & ~h_i_mem_ack;
  assign rsMatch = (h_i_ex_rd == h_i_id_rs);
  assign rtMatch = h_i_id_uses_rt & (h_i_ex_rd == h_i_id_rt);
  assign loadUse = h_i_id_valid & h_i_ex_memread & h_i_ex_reg_wr &
                   (h_i_ex_rd != 5'd0) & (rsMatch | rtMatch);
  assign inWait  = (state_q == ST_MEM_WAIT);

  always_comb begin
    pcWe    = 1'b0;
    ifidWe  = 1'b0;
    idexWe  = 1'b0;
    exmemWe = 1'b0;
    flush   = 1'b0;
    bubble  = 1'b0;
    if (!h_i_rst && h_i_ce && !freeze) begin
      if (h_i_ex_branch_taken) begin
        pcWe    = 1'b1;
        ifidWe  = 1'b1;
        idexWe  = 1'b1;
        exmemWe = 1'b1;
        flush   = 1'b1;
        bubble  = 1'b1;
      end else if (loadUse) begin
        idexWe  = 1'b1;
        exmemWe = 1'b1;
        bubble  = 1'b1;
      end else begin
        pcWe    = 1'b1;
        ifidWe  = 1'b1;
        idexWe  = 1'b1;
        exmemWe = 1'b1;
      end
    end
  end

  // A hazard seen while already in LOAD_STALL stalls again but still returns to RUN.
  always_comb begin
    state_d = ST_RUN;
    case (state_q)
      ST_RUN: begin
        if (freeze)                                   state_d = ST_MEM_WAIT;
        else if (loadUse && !h_i_ex_branch_taken)     state_d = ST_LOAD_STALL;
        else                                          state_d = ST_RUN;
      end
      ST_LOAD_STALL: state_d = freeze ? ST_MEM_WAIT : ST_RUN;
      ST_MEM_WAIT:   state_d = freeze ? ST_MEM_WAIT : ST_RUN;
      default:       state_d = ST_RUN;
    endcase
  end

  always_comb begin
    waitInc    = (waitCnt_q == 8'hFF) ? 8'hFF : waitCnt_q + 8'd1;
    waitCnt_d  = inWait ? waitInc : 8'd0;
    timeout_d  = timeout_q | (inWait & freeze & (waitInc == 8'hFF));
    stallCnt_d = (!pcWe && (stallCnt_q != 16'hFFFF)) ? stallCnt_q + 16'd1 : stallCnt_q;
  end

  always_ff @(posedge h_i_clk or posedge h_i_rst) begin
    if (h_i_rst) begin
      state_q    <= ST_RUN;
      waitCnt_q  <= 8'd0;
      stallCnt_q <= 16'd0;
      timeout_q  <= 1'b0;
    end else if (h_i_ce) begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      stallCnt_q <= stallCnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign h_o_pc_we       = pcWe;
  assign h_o_ifid_we     = ifidWe;
  assign h_o_idex_we     = idexWe;
  assign h_o_exmem_we    = exmemWe;
  assign h_o_ifid_flush  = flush;
  assign h_o_idex_bubble = bubble;
  assign h_o_state       = state_q;
  assign h_o_stall_cnt   = stallCnt_q;
  assign h_o_mem_timeout = timeout_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: stall, flush, freeze, timeout and async reset scenarios
// with hand-computed expectations checked by immediate assertions.
module tb_hazard_unit;

  logic        clk, rst, ce;
  logic        idValid, idUsesRt, exMemRead, exRegWr, brTaken, memReq, memAck;
  logic [4:0]  idRs, idRt, exRd;
  logic        pcWe, ifidWe, idexWe, exmemWe, ifidFlush, idexBubble, memTimeout;
  logic [1:0]  state;
  logic [15:0] stallCnt;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  localparam logic [1:0] RUN = 2'd0, LSTALL = 2'd1, MWAIT = 2'd2;
  // Control vector order: {pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_bubble}
  localparam logic [5:0] CTL_IDLE = 6'b111100, CTL_LU = 6'b001101,
                         CTL_BR = 6'b111111, CTL_OFF = 6'b000000;

  hazard_unit dut (
    .h_i_clk(clk), .h_i_rst(rst), .h_i_ce(ce),
    .h_i_id_valid(idValid), .h_i_id_uses_rt(idUsesRt),
    .h_i_id_rs(idRs), .h_i_id_rt(idRt),
    .h_i_ex_memread(exMemRead), .h_i_ex_reg_wr(exRegWr), .h_i_ex_rd(exRd),
    .h_i_ex_branch_taken(brTaken),
    .h_i_mem_req(memReq), .h_i_mem_ack(memAck),
    .h_o_pc_we(pcWe), .h_o_ifid_we(ifidWe), .h_o_idex_we(idexWe), .h_o_exmem_we(exmemWe),
    .h_o_ifid_flush(ifidFlush), .h_o_idex_bubble(idexBubble),
    .h_o_state(state), .h_o_stall_cnt(stallCnt), .h_o_mem_timeout(memTimeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic applyStimulus(input logic valid, input logic usesRt, input logic [4:0] rs,
                               input logic [4:0] rt, input logic memRead, input logic regWr,
                               input logic [4:0] rd, input logic br, input logic req,
                               input logic ack);
    idValid = valid; idUsesRt = usesRt; idRs = rs; idRt = rt;
    exMemRead = memRead; exRegWr = regWr; exRd = rd;
    brTaken = br; memReq = req; memAck = ack;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount = checkCount + 1;
    assert (obs === exp) passCount = passCount + 1;
    else begin
      failCount = failCount + 1;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkCtl(input string tag, input logic [5:0] exp);
    checkOutput(tag, {26'd0, pcWe, ifidWe, idexWe, exmemWe, ifidFlush, idexBubble}, {26'd0, exp});
  endtask

  task automatic checkRegs(input string tag, input logic [1:0] expState,
                           input logic [15:0] expStall, input logic expTimeout);
    checkOutput({tag, ".state"},   {30'd0, state},      {30'd0, expState});
    checkOutput({tag, ".stall"},   {16'd0, stallCnt},   {16'd0, expStall});
    checkOutput({tag, ".timeout"}, {31'd0, memTimeout}, {31'd0, expTimeout});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    ce  = 1'b1;
    applyStimulus(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    #1;
    checkRegs("reset", RUN, 16'd0, 1'b0);
    checkCtl("reset.ctl", CTL_OFF);
    #10 rst = 1'b0;
    tick();

    applyStimulus(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    checkCtl("idle.ctl", CTL_IDLE);

    // Load-use on rs: one stall cycle, RUN -> LOAD_STALL -> RUN.
    applyStimulus(1, 0, 5'd5, 5'd0, 1, 1, 5'd5, 0, 0, 0);
    checkCtl("lu_rs.ctl", CTL_LU);
    tick();
    checkRegs("lu_rs.edge", LSTALL, 16'd1, 1'b0);
    applyStimulus(1, 0, 5'd5, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    checkCtl("lu_rs.after", CTL_IDLE);
    tick();
    checkRegs("lu_rs.back", RUN, 16'd1, 1'b0);

    // $zero destination and rt-not-used filtering.
    applyStimulus(1, 0, 5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 0);
    checkCtl("zero_rd.ctl", CTL_IDLE);
    applyStimulus(1, 0, 5'd3, 5'd7, 1, 1, 5'd7, 0, 0, 0);
    checkCtl("rt_unused.ctl", CTL_IDLE);
    applyStimulus(1, 1, 5'd3, 5'd7, 1, 1, 5'd7, 0, 0, 0);
    checkCtl("rt_used.ctl", CTL_LU);
    tick();
    checkRegs("rt_used.edge", LSTALL, 16'd2, 1'b0);

    // Back-to-back hazard while in LOAD_STALL: stall again, then RUN.
    checkCtl("b2b.ctl", CTL_LU);
    tick();
    checkRegs("b2b.edge", RUN, 16'd3, 1'b0);

    // Branch with coincident load-use: flush wins, no stall.
    applyStimulus(1, 0, 5'd5, 5'd0, 1, 1, 5'd5, 1, 0, 0);
    checkCtl("br_lu.ctl", CTL_BR);
    tick();
    checkRegs("br_lu.edge", RUN, 16'd3, 1'b0);

    // Clock enable low: outputs off, state and counters hold.
    ce = 1'b0;
    applyStimulus(1, 0, 5'd5, 5'd0, 1, 1, 5'd5, 0, 0, 0);
    checkCtl("ce_off.ctl", CTL_OFF);
    tick();
    checkRegs("ce_off.edge", RUN, 16'd3, 1'b0);
    ce = 1'b1;

    // Memory wait with a concurrent branch, ack after three frozen cycles.
    applyStimulus(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 1, 0);
    checkCtl("mw.c0", CTL_OFF);
    tick();
    checkRegs("mw.e1", MWAIT, 16'd4, 1'b0);
    checkCtl("mw.c1", CTL_OFF);
    tick();
    checkRegs("mw.e2", MWAIT, 16'd5, 1'b0);
    checkCtl("mw.c2", CTL_OFF);
    tick();
    checkRegs("mw.e3", MWAIT, 16'd6, 1'b0);
    applyStimulus(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 1, 1);
    checkCtl("mw.ack", CTL_BR);
    tick();
    checkRegs("mw.done", RUN, 16'd6, 1'b0);

    // Request acknowledged in the same cycle: no freeze.
    applyStimulus(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1);
    checkCtl("req_ack.ctl", CTL_IDLE);
    tick();
    checkRegs("req_ack.edge", RUN, 16'd6, 1'b0);

    // LOAD_STALL -> MEM_WAIT, then asynchronous reset between edges.
    applyStimulus(1, 0, 5'd9, 5'd0, 1, 1, 5'd9, 0, 0, 0);
    tick();
    checkRegs("ls.edge", LSTALL, 16'd7, 1'b0);
    applyStimulus(1, 0, 5'd9, 5'd0, 1, 1, 5'd9, 0, 1, 0);
    checkCtl("ls_freeze.ctl", CTL_OFF);
    tick();
    checkRegs("ls_freeze.edge", MWAIT, 16'd8, 1'b0);
    #2 rst = 1'b1;
    #1;
    checkRegs("async_rst", RUN, 16'd0, 1'b0);
    checkCtl("async_rst.ctl", CTL_OFF);
    #2 rst = 1'b0;
    applyStimulus(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    tick();
    checkRegs("post_rst", RUN, 16'd0, 1'b0);
    checkCtl("post_rst.ctl", CTL_IDLE);

    // Timeout: flag rises at the edge closing the 255th MEM_WAIT cycle.
    applyStimulus(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0);
    repeat (255) tick();
    checkRegs("to.before", MWAIT, 16'd255, 1'b0);
    tick();
    checkRegs("to.rise", MWAIT, 16'd256, 1'b1);
    repeat (44) tick();
    checkRegs("to.300", MWAIT, 16'd300, 1'b1);
    checkCtl("to.ctl", CTL_OFF);
    applyStimulus(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1);
    checkCtl("to.ack", CTL_IDLE);
    tick();
    applyStimulus(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    repeat (3) tick();
    checkRegs("to.sticky", RUN, 16'd300, 1'b1);
    #2 rst = 1'b1;
    #1;
    checkRegs("to.clear", RUN, 16'd0, 1'b0);
    #2 rst = 1'b0;
    tick();

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
